traffic_intersection: RTL and testbench



---
 rtl/traffic_pkg.sv | 56 +++++
 rtl/phase_timer.sv | 37 +++
 rtl/traffic_intersection.sv | 185 ++++++++++++++++++
 tb/tb_traffic_intersection.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp patterns for the two-direction intersection controller.
package traffic_pkg;

  localparam int unsigned PHASE_W = 4;

  // Controller states; numeric values are what appears on the phase debug port.
  typedef enum logic [PHASE_W-1:0] {
    ST_AR_A  = 4'd0,
    ST_RO_A  = 4'd1,
    ST_GR_A  = 4'd2,
    ST_OR_A  = 4'd3,
    ST_AR_B  = 4'd4,
    ST_RO_B  = 4'd5,
    ST_GR_B  = 4'd6,
    ST_OR_B  = 4'd7,
    ST_FLASH = 4'd8
  } state_e;

  // One bit per lamp, head A first.
  typedef struct packed {
    logic red_a;
    logic orange_a;
    logic green_a;
    logic red_b;
    logic orange_b;
    logic green_b;
  } lamps_t;

  localparam lamps_t LAMPS_OFF  = lamps_t'(6'b000_000);
  localparam lamps_t LAMPS_AR   = lamps_t'(6'b100_100);
  localparam lamps_t LAMPS_RO_A = lamps_t'(6'b110_100);
  localparam lamps_t LAMPS_GR_A = lamps_t'(6'b001_100);
  localparam lamps_t LAMPS_OR_A = lamps_t'(6'b010_100);
  localparam lamps_t LAMPS_RO_B = lamps_t'(6'b100_110);
  localparam lamps_t LAMPS_GR_B = lamps_t'(6'b100_001);
  localparam lamps_t LAMPS_OR_B = lamps_t'(6'b100_010);

  // Steady lamp pattern for a state; FLASH oranges are overlaid by the controller.
  function automatic lamps_t lamp_pattern(input state_e s);
    lamps_t l;
    l = LAMPS_AR;
    case (s)
      ST_AR_A, ST_AR_B: l = LAMPS_AR;
      ST_RO_A:          l = LAMPS_RO_A;
      ST_GR_A:          l = LAMPS_GR_A;
      ST_OR_A:          l = LAMPS_OR_A;
      ST_RO_B:          l = LAMPS_RO_B;
      ST_GR_B:          l = LAMPS_GR_B;
      ST_OR_B:          l = LAMPS_OR_B;
      ST_FLASH:         l = LAMPS_OFF;
      default:          l = LAMPS_AR;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the current phase; expire_c flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned       CNT_W   = 8,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c = (count_q == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Two-direction intersection controller with all-red clearance, pedestrian walk and night flashing.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned ALLRED_CYC     = 2,
  parameter int unsigned RED_ORANGE_CYC = 1,
  parameter int unsigned GREEN_CYC      = 8,
  parameter int unsigned ORANGE_CYC     = 2,
  parameter int unsigned PED_CYC        = 5,
  parameter int unsigned FLASH_HALF     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               night,
  input  logic               ped_req,
  output logic               red_a,
  output logic               orange_a,
  output logic               green_a,
  output logic               red_b,
  output logic               orange_b,
  output logic               green_b,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Reject durations that cannot be represented by the phase timer.
  if (ALLRED_CYC < 1 || ALLRED_CYC > CNT_MAX) begin : g_bad_allred
    $error("ALLRED_CYC out of range");
  end
  if (RED_ORANGE_CYC < 1 || RED_ORANGE_CYC > CNT_MAX) begin : g_bad_ro
    $error("RED_ORANGE_CYC out of range");
  end
  if (GREEN_CYC < 1 || GREEN_CYC > CNT_MAX) begin : g_bad_green
    $error("GREEN_CYC out of range");
  end
  if (ORANGE_CYC < 1 || ORANGE_CYC > CNT_MAX) begin : g_bad_orange
    $error("ORANGE_CYC out of range");
  end
  if (PED_CYC < 1 || PED_CYC > CNT_MAX) begin : g_bad_ped
    $error("PED_CYC out of range");
  end
  if (FLASH_HALF < 1 || FLASH_HALF > CNT_MAX) begin : g_bad_flash
    $error("FLASH_HALF out of range");
  end

  localparam logic [CNT_W-1:0] AR_VAL    = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] RO_VAL    = CNT_W'(RED_ORANGE_CYC - 1);
  localparam logic [CNT_W-1:0] GR_VAL    = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] OR_VAL    = CNT_W'(ORANGE_CYC - 1);
  localparam logic [CNT_W-1:0] PED_VAL   = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_VAL = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  logic             ped_q, ped_d;
  logic             flash_q, flash_d;
  logic             walk_q, walk_d;
  lamps_t           lamps_q, lamps_d;
  logic             enter_ar;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire_c;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (AR_VAL)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire_c (tmr_expire_c)
  );

  // Next state, timer reload, pedestrian latch, flash phase and lamp decode of the next state.
  always_comb begin
    state_d  = state_q;
    ped_d    = ped_q | ped_req;
    flash_d  = flash_q;
    walk_d   = walk_q;
    enter_ar = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (state_q == ST_FLASH) begin
      if (!night) begin
        state_d  = ST_AR_A;
        flash_d  = 1'b0;
        enter_ar = 1'b1;
      end else if (tmr_expire_c) begin
        flash_d  = ~flash_q;
        tmr_load = 1'b1;
        tmr_val  = FLASH_VAL;
      end
    end else if (tmr_expire_c) begin
      tmr_load = 1'b1;
      walk_d   = 1'b0;
      case (state_q)
        ST_AR_A, ST_AR_B: begin
          if (night) begin
            state_d = ST_FLASH;
            flash_d = 1'b1;
            tmr_val = FLASH_VAL;
          end else begin
            state_d = (state_q == ST_AR_A) ? ST_RO_A : ST_RO_B;
            tmr_val = RO_VAL;
          end
        end
        ST_RO_A: begin
          state_d = ST_GR_A;
          tmr_val = GR_VAL;
        end
        ST_RO_B: begin
          state_d = ST_GR_B;
          tmr_val = GR_VAL;
        end
        ST_GR_A: begin
          state_d = ST_OR_A;
          tmr_val = OR_VAL;
        end
        ST_GR_B: begin
          state_d = ST_OR_B;
          tmr_val = OR_VAL;
        end
        ST_OR_A: begin
          state_d  = ST_AR_B;
          enter_ar = 1'b1;
        end
        ST_OR_B: begin
          state_d  = ST_AR_A;
          enter_ar = 1'b1;
        end
        default: begin
          state_d  = ST_AR_A;
          enter_ar = 1'b1;
        end
      endcase
    end

    // A latched request turns the coming all-red into a walk phase and is consumed by it.
    if (enter_ar) begin
      tmr_load = 1'b1;
      walk_d   = ped_q;
      tmr_val  = ped_q ? PED_VAL : AR_VAL;
      if (ped_q) begin
        ped_d = ped_req;
      end
    end

    lamps_d = lamp_pattern(state_d);
    if (state_d == ST_FLASH) begin
      lamps_d.orange_a = flash_d;
      lamps_d.orange_b = flash_d;
    end
  end

  // State and registered lamp outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_AR_A;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      walk_q  <= 1'b0;
      lamps_q <= LAMPS_AR;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      walk_q  <= walk_d;
      lamps_q <= lamps_d;
    end
  end

  assign red_a    = lamps_q.red_a;
  assign orange_a = lamps_q.orange_a;
  assign green_a  = lamps_q.green_a;
  assign red_b    = lamps_q.red_b;
  assign orange_b = lamps_q.orange_b;
  assign green_b  = lamps_q.green_b;
  assign walk     = walk_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// Bench for traffic_intersection: directed phase tables plus randomized run against a phase-table model.
module tb_traffic_intersection;

  localparam int ALLRED = 2;
  localparam int RO     = 1;
  localparam int GR     = 8;
  localparam int ORG    = 2;
  localparam int PED    = 5;
  localparam int FH     = 3;

  // Expected {red_a, orange_a, green_a, red_b, orange_b, green_b, walk}.
  localparam logic [6:0] E_AR   = 7'b100_100_0;
  localparam logic [6:0] E_ARW  = 7'b100_100_1;
  localparam logic [6:0] E_ROA  = 7'b110_100_0;
  localparam logic [6:0] E_GRA  = 7'b001_100_0;
  localparam logic [6:0] E_ORA  = 7'b010_100_0;
  localparam logic [6:0] E_ROB  = 7'b100_110_0;
  localparam logic [6:0] E_GRB  = 7'b100_001_0;
  localparam logic [6:0] E_ORB  = 7'b100_010_0;
  localparam logic [6:0] E_FON  = 7'b010_010_0;
  localparam logic [6:0] E_FOFF = 7'b000_000_0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       night = 1'b0;
  logic       ped_req = 1'b0;
  logic       red_a, orange_a, green_a, red_b, orange_b, green_b, walk;
  logic [3:0] phase;

  int vectors = 0;
  int miscompares = 0;

  traffic_intersection dut (
    .clk      (clk),
    .rst      (rst),
    .night    (night),
    .ped_req  (ped_req),
    .red_a    (red_a),
    .orange_a (orange_a),
    .green_a  (green_a),
    .red_b    (red_b),
    .orange_b (orange_b),
    .green_b  (green_b),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    bit         night;
    bit         ped;
    int         cycles;
    logic [6:0] exp;
  } rec_t;

  rec_t tbl[$];

  function automatic rec_t mk(bit rb, bit n, bit p, int c, logic [6:0] e);
    rec_t r;
    r.rst_before = rb;
    r.night      = n;
    r.ped        = p;
    r.cycles     = c;
    r.exp        = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {red_a, orange_a, green_a, red_b, orange_b, green_b, walk};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: lamps/walk got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Safety properties, checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ((green_a && green_b) || (walk && (green_a || green_b)) ||
          (green_a && (red_a || orange_a)) || (green_b && (red_b || orange_b))) begin
        miscompares++;
        $display("FAIL safety: lamps %b%b%b %b%b%b walk %b", red_a, orange_a, green_a,
                 red_b, orange_b, green_b, walk);
      end
    end
  end

  // Reference model: position in the 8-phase cycle, cycles spent there, and the phase length.
  int         dur_tab[8] = '{ALLRED, RO, GR, ORG, ALLRED, RO, GR, ORG};
  logic [5:0] lamp_tab[8] = '{6'b100100, 6'b110100, 6'b001100, 6'b010100,
                              6'b100100, 6'b100110, 6'b100001, 6'b100010};
  int m_idx, m_age, m_dur;
  bit m_flash, m_walk, m_ped;

  task automatic model_reset();
    m_idx = 0; m_age = 0; m_dur = ALLRED; m_flash = 0; m_walk = 0; m_ped = 0;
  endtask

  task automatic model_enter_ar(input int i, input bit p);
    bit served;
    served  = m_ped;
    m_idx   = i;
    m_flash = 0;
    m_age   = 0;
    m_dur   = served ? PED : dur_tab[i];
    m_walk  = served;
    m_ped   = served ? p : (m_ped | p);
  endtask

  task automatic model_step(input bit n, input bit p);
    int nidx;
    if (m_flash) begin
      if (!n) model_enter_ar(0, p);
      else begin m_age++; m_ped |= p; end
    end else if (m_age + 1 >= m_dur) begin
      if ((m_idx % 4 == 0) && n) begin
        m_flash = 1; m_age = 0; m_walk = 0; m_ped |= p;
      end else begin
        nidx = (m_idx + 1) % 8;
        if (nidx % 4 == 0) model_enter_ar(nidx, p);
        else begin
          m_idx = nidx; m_age = 0; m_dur = dur_tab[nidx]; m_walk = 0; m_ped |= p;
        end
      end
    end else begin
      m_age++;
      m_ped |= p;
    end
  endtask

  function automatic logic [6:0] model_exp();
    bit o;
    if (m_flash) begin
      o = ((m_age / FH) % 2) == 0;
      return {1'b0, o, 1'b0, 1'b0, o, 1'b0, 1'b0};
    end
    return {lamp_tab[m_idx], m_walk};
  endfunction

  initial begin
    // Idle cycle after reset: full 26-cycle period and wrap to A.
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 0, GR, E_GRA));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORA));
    tbl.push_back(mk(0, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROB));
    tbl.push_back(mk(0, 0, 0, GR, E_GRB));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORB));
    tbl.push_back(mk(0, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    // Single-cycle ped pulse in GR_A: AR_B becomes a 5-cycle walk, next AR_A normal.
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 1, 1, E_GRA));
    tbl.push_back(mk(0, 0, 0, GR - 1, E_GRA));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORA));
    tbl.push_back(mk(0, 0, 0, PED, E_ARW));
    tbl.push_back(mk(0, 0, 0, RO, E_ROB));
    tbl.push_back(mk(0, 0, 0, GR, E_GRB));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORB));
    tbl.push_back(mk(0, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    // ped held through the AR_B walk re-arms the latch: AR_A is also a walk.
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 1, 1, E_GRA));
    tbl.push_back(mk(0, 0, 0, GR - 1, E_GRA));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORA));
    tbl.push_back(mk(0, 0, 1, PED, E_ARW));
    tbl.push_back(mk(0, 0, 0, RO, E_ROB));
    tbl.push_back(mk(0, 0, 0, GR, E_GRB));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORB));
    tbl.push_back(mk(0, 0, 0, PED, E_ARW));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    // night raised in GR_B: no effect until AR_A expiry, then flashing; release returns to AR_A.
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 0, GR, E_GRA));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORA));
    tbl.push_back(mk(0, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROB));
    tbl.push_back(mk(0, 1, 0, GR, E_GRB));
    tbl.push_back(mk(0, 1, 0, ORG, E_ORB));
    tbl.push_back(mk(0, 1, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 1, 0, FH, E_FON));
    tbl.push_back(mk(0, 1, 0, FH, E_FOFF));
    tbl.push_back(mk(0, 1, 0, FH - 1, E_FON));
    tbl.push_back(mk(0, 0, 0, 1, E_FON));
    tbl.push_back(mk(0, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 0, 2, E_GRA));
    // Async reset in the middle of GR_A: immediate all-red, sequence restarts from AR_A.
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 0, 3, E_GRA));
    tbl.push_back(mk(1, 0, 0, ALLRED, E_AR));
    tbl.push_back(mk(0, 0, 0, RO, E_ROA));
    tbl.push_back(mk(0, 0, 0, GR, E_GRA));
    tbl.push_back(mk(0, 0, 0, ORG, E_ORA));

    @(negedge clk);
    foreach (tbl[k]) begin
      if (tbl[k].rst_before) begin
        #2;
        rst = 1'b0; night = 1'b0; ped_req = 1'b0;
        #1;
        check($sformatf("rec%0d_reset", k), E_AR);
        @(negedge clk);
        rst = 1'b1;
      end
      for (int c = 0; c < tbl[k].cycles; c++) begin
        night   = tbl[k].night;
        ped_req = tbl[k].ped;
        #1;
        check($sformatf("rec%0d_cyc%0d", k, c), tbl[k].exp);
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Randomized run against the reference model.
    #2;
    rst = 1'b0; night = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) night = ~night;
      ped_req = ($urandom_range(0, 11) == 0);
      #1;
      check($sformatf("rand%0d", i), model_exp());
      model_step(night, ped_req);
      @(posedge clk);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
